axis_uart_rx: RTL

- UART receiver: 8N1 serial stream on uart_rx → bytes on an AXI-Stream master interface.
- Inbound counterpart of the UART transmitter; sits at the pad boundary and feeds the command/loopback path.
- Single-entry output register with overrun and framing-error status pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/axis_uart_rx_if.sv | 16 +
 rtl/uart_sync_2ff.sv | 28 ++
 rtl/axis_uart_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter blocks.
//   uart_state_e : frame FSM state. The 3-bit encoding is common to RX and TX
//                  so debug tooling decodes both the same way.
//   DATA_BITS    : payload bits per frame.
//   baud_div()   : clocks per bit for a given clock and line rate.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int baud_div(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/axis_uart_rx_if.sv
// AXI-Stream byte channel used by the UART receiver.
//   tdata  : byte, LSB = first bit received on the line
//   tvalid : byte available
//   tready : downstream accept
// Handshake: a beat transfers on a rising aclk edge where tvalid && tready.
// Once tvalid is high, the master holds tvalid and tdata stable until that
// transfer happens. tvalid never depends combinationally on tready. The slave
// may drive tready at any time.
interface axis_uart_rx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input.
//   aclk, aresetn : clock and synchronous active-low reset
//   d             : asynchronous input
//   q             : synchronized output, reset to RESET_VAL
// Both flops reset to RESET_VAL, so a line that idles at that level shows no
// spurious edge after reset is released.
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver: decodes an 8N1 serial line into bytes on an AXI-Stream master.
// The output is a single register. frame_err and overrun are one-cycle pulses.
//   aclk, aresetn : clock and synchronous active-low reset
//   uart_rx       : asynchronous serial input, idle high
//   m_axis        : byte output (tdata / tvalid / tready)
//   frame_err     : pulse when the stop bit is sampled low. The byte is dropped.
//   overrun       : pulse when a byte completes while the output register is
//                   still full. The new byte is dropped.
//   parity_err    : (AXIS_UART_RX_PARITY_EN only) pulse in the delivery cycle
//                   of a byte whose even parity check failed
//   state_dbg     : current FSM state, for observation
// Build option: define AXIS_UART_RX_PARITY_EN for 8E1 frames. This adds an
// even-parity bit between the data bits and the stop bit.
module axis_uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK     = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  uart_rx,
  axis_uart_rx_if.master        m_axis,
  output logic                  frame_err,
  output logic                  overrun,
`ifdef AXIS_UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output uart_state_e           state_dbg
);

  localparam int COUNT_SPEED = baud_div(CLOCK, BAUD_RATE);
  localparam int HALF        = COUNT_SPEED / 2;
  localparam int CW          = $clog2(COUNT_SPEED);

  localparam logic [CW-1:0] LAST_CNT  = CW'(COUNT_SPEED - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state;
  logic [CW-1:0]        count_baud;
  logic [2:0]           count_bit;
  logic [DATA_BITS-1:0] shift_reg;
  // Set at the stop-bit sample edge. The output register acts on it one
  // cycle later.
  logic                 deliver;
`ifdef AXIS_UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .d       (uart_rx),
    .q       (rx_s)
  );

  assign state_dbg = state;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      count_baud    <= '0;
      count_bit     <= '0;
      shift_reg     <= '0;
      deliver       <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
`ifdef AXIS_UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      case (state)
        IDLE: begin
          // A line held low re-triggers here after every frame. That gives
          // one frame_err per frame time during a break.
          if (!rx_s) begin
            state      <= START;
            count_baud <= '0;
          end
        end

        START: begin
          // Re-check at the middle of the start bit. A pulse shorter than
          // half a bit goes back to IDLE without raising any status.
          if (count_baud == HALF_LAST) begin
            count_baud <= '0;
            count_bit  <= '0;
            state      <= rx_s ? IDLE : DATA;
          end else begin
            count_baud <= count_baud + 1'b1;
          end
        end

        DATA: begin
          if (count_baud == LAST_CNT) begin
            count_baud <= '0;
            // LSB arrives first, so shift in from the top.
            shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (count_bit == LAST_BIT) begin
`ifdef AXIS_UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              count_bit <= count_bit + 1'b1;
            end
          end else begin
            count_baud <= count_baud + 1'b1;
          end
        end

`ifdef AXIS_UART_RX_PARITY_EN
        PARITY: begin
          if (count_baud == LAST_CNT) begin
            count_baud <= '0;
            // Even parity: data bits plus parity bit hold an even number of ones.
            par_bad    <= ^{shift_reg, rx_s};
            state      <= STOP;
          end else begin
            count_baud <= count_baud + 1'b1;
          end
        end
`endif

        STOP: begin
          // The decision is made at the middle of the stop bit. The FSM does
          // not wait for the end of the bit, which leaves half a bit of
          // tolerance for rate mismatch.
          if (count_baud == LAST_CNT) begin
            count_baud <= '0;
            state      <= IDLE;
            if (rx_s) deliver   <= 1'b1;
            else      frame_err <= 1'b1;
          end else begin
            count_baud <= count_baud + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          count_baud <= '0;
        end
      endcase

      // Single-entry output register. A new byte may replace the old one
      // only in a cycle where the old one is being accepted.
      if (deliver) begin
        if (!m_axis.tvalid || m_axis.tready) begin
          m_axis.tdata  <= shift_reg;
          m_axis.tvalid <= 1'b1;
`ifdef AXIS_UART_RX_PARITY_EN
          parity_err    <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_axis.tvalid && m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule
